// File: rtl/bomb_sprite_ctrl.sv
// Bomb sprite pixel sequencer: maps the scan position to sprite ROM
// addresses and steers the returned colour index through the bomb palette.
// It registers a pixel-aligned RGB / sprite_on pair and runs the bomb
// lifecycle FSM (IDLE -> ACTIVE -> FLASH -> DONE) with the white flash overlay.
// Scan-to-output latency is fixed at 3 clocks:
//   edge 1: rom_addr, in_box_d1, flash_d1
//   edge 2: ROM registers rom_index; in_box_d2, flash_d2
//   edge 3: sprite_on, red/green/blue
module bomb_sprite_ctrl #(
  parameter int          SPR_W        = 32,
  parameter int          SPR_H        = 32,
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  TRANSP_IDX   = 8'd255,
  parameter int          FLASH_FRAMES = 24,
  parameter int          FLASH_PERIOD = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        bomb_x,
  input  logic [9:0]        bomb_y,
  input  logic              bomb_active,
  input  logic              bomb_hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_index,
  output logic [7:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on,
  output logic              explode_done,
  output logic [1:0]        state_dbg
);

  // SPR_W is a power of two, so the ROM address is {row offset, column offset}.
  localparam int X_BITS = $clog2(SPR_W);
  localparam int Y_BITS = ADDR_W - X_BITS;
  localparam int CNT_W  = $clog2(FLASH_FRAMES + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(FLASH_PERIOD);
  localparam logic [10:0]      W_EXT    = 11'(SPR_W);
  localparam logic [10:0]      H_EXT    = 11'(SPR_H);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLASH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_period_end;
  logic               r_flash_on;
  logic               w_flash_on_nxt;
  logic               r_explode_done;
  logic               w_done_nxt;
  logic               w_pos_load;
  logic [9:0]         r_pos_x;
  logic [9:0]         r_pos_y;

  logic [10:0]        w_x_end;
  logic [10:0]        w_y_end;
  logic               w_draw_state;
  logic               w_in_box;
  logic               w_flash_px;
  logic [X_BITS-1:0]  w_dx;
  logic [Y_BITS-1:0]  w_dy;

  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_in_box_d1;
  logic               r_flash_d1;
  logic               r_in_box_d2;
  logic               r_flash_d2;
  logic               w_opaque;
  logic               r_sprite_on;
  logic [3:0]         r_red;
  logic [3:0]         r_green;
  logic [3:0]         r_blue;

  // Frame counter step and flash half-period boundary.
  assign w_cnt_inc    = r_frame_cnt + 1'b1;
  assign w_period_end = ((w_cnt_inc % PERIOD) == '0);

  // Position only follows the game while the bomb is idle or live, on a frame boundary.
  assign w_pos_load = frame_start && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic plus frame counter / flash phase / done pulse updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_frame_cnt;
    w_flash_on_nxt = r_flash_on;
    w_done_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start && bomb_active) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A hit wins over a simultaneous frame boundary.
        if (bomb_hit) begin
          w_state_nxt    = ST_FLASH;
          w_cnt_nxt      = '0;
          w_flash_on_nxt = 1'b1;
        end else if (frame_start && !bomb_active) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLASH: begin
        if (frame_start) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_period_end) w_flash_on_nxt = ~r_flash_on;
          if (r_frame_cnt == LAST_CNT) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (frame_start && !bomb_active) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lifecycle bookkeeping registers: counter, flash phase, done pulse, latched position.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_cnt    <= '0;
      r_flash_on     <= 1'b0;
      r_explode_done <= 1'b0;
      r_pos_x        <= '0;
      r_pos_y        <= '0;
    end else begin
      r_frame_cnt    <= w_cnt_nxt;
      r_flash_on     <= w_flash_on_nxt;
      r_explode_done <= w_done_nxt;
      if (w_pos_load) begin
        r_pos_x <= bomb_x;
        r_pos_y <= bomb_y;
      end
    end
  end

  // Box test in 11 bits so a sprite hanging off the right/bottom never wraps to 0.
  assign w_x_end      = {1'b0, r_pos_x} + W_EXT;
  assign w_y_end      = {1'b0, r_pos_y} + H_EXT;
  assign w_draw_state = (r_state == ST_ACTIVE) || (r_state == ST_FLASH);
  assign w_in_box     = pixel_valid && w_draw_state &&
                        (DrawX >= r_pos_x) && ({1'b0, DrawX} < w_x_end) &&
                        (DrawY >= r_pos_y) && ({1'b0, DrawY} < w_y_end);
  assign w_flash_px   = (r_state == ST_FLASH) && r_flash_on;

  // Offsets are only meaningful inside the box, so low bits suffice.
  assign w_dx = DrawX[X_BITS-1:0] - r_pos_x[X_BITS-1:0];
  assign w_dy = DrawY[Y_BITS-1:0] - r_pos_y[Y_BITS-1:0];

  // Stage 1: ROM address (held outside the box) and per-pixel flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rom_addr  <= '0;
      r_in_box_d1 <= 1'b0;
      r_flash_d1  <= 1'b0;
    end else begin
      if (w_in_box) r_rom_addr <= {w_dy, w_dx};
      r_in_box_d1 <= w_in_box;
      r_flash_d1  <= w_flash_px;
    end
  end

  // Stage 2: flags travel alongside the ROM's own read register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_in_box_d2 <= 1'b0;
      r_flash_d2  <= 1'b0;
    end else begin
      r_in_box_d2 <= r_in_box_d1;
      r_flash_d2  <= r_flash_d1;
    end
  end

  // The palette is a combinational lookup on the ROM data.
  assign pal_index = rom_index;
  assign w_opaque  = r_in_box_d2 && (rom_index != TRANSP_IDX);

  // Stage 3: pixel-aligned colour; black whenever the pixel is not an opaque bomb pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sprite_on <= 1'b0;
      r_red       <= 4'h0;
      r_green     <= 4'h0;
      r_blue      <= 4'h0;
    end else begin
      r_sprite_on <= w_opaque;
      if (!w_opaque) begin
        r_red   <= 4'h0;
        r_green <= 4'h0;
        r_blue  <= 4'h0;
      end else if (r_flash_d2) begin
        r_red   <= 4'hF;
        r_green <= 4'hF;
        r_blue  <= 4'hF;
      end else begin
        r_red   <= pal_red;
        r_green <= pal_green;
        r_blue  <= pal_blue;
      end
    end
  end

  assign rom_addr     = r_rom_addr;
  assign sprite_on    = r_sprite_on;
  assign red          = r_red;
  assign green        = r_green;
  assign blue         = r_blue;
  assign explode_done = r_explode_done;
  assign state_dbg    = r_state;

endmodule
